// File: rtl/soin_bpredictor_update_fifo.sv
// ----------------------------------------------------------------------------
// soin_bpredictor_update_fifo
//
// Purpose:
//   Sits between execute and the bimodal predictor's update port. Resolved
//   branches are checked for direction/target misprediction. Entries that must
//   reach the predictor are queued in order: conditional branches, and any
//   mispredicted branch so the RAS can be restored. One entry per cycle is
//   drained into registered execute_bpredictor_* outputs. The new 2-bit
//   saturating counter byte and its lane byte-enable are computed at drain
//   time, so execute never performs the predictor read-modify-write itself.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   execute_branch_valid/_ready     handshake from execute (ready = ~full)
//   execute_branch_PC/_target       branch PC and actual target
//   execute_branch_dir/_is_cond     actual direction, conditional flag
//   execute_branch_p_dir/_p_target  prediction made by fetch
//   execute_branch_meta[19:0]       {ras[3:0], byte[7:0], idx[7:0]} from fetch
//   soin_bpredictor_stall           holds the drain; the FIFO keeps accepting
//   execute_bpredictor_*            drained entry, valid for one cycle
//     meta[23:0] = {ras[3:0], be[3:0], new_byte[7:0], idx[7:0]}
//   update_fifo_count               FIFO occupancy
//
// Configuration macro:
//   SOIN_BP_UPDATE_BYPASS_EN  when defined, the counter byte written by the
//   last conditional pop is reused as the base byte if the next conditional
//   pop targets the same idx/lane. This covers fetch meta that was read
//   before the previous update landed.
// ----------------------------------------------------------------------------
module soin_bpredictor_update_fifo #(
  parameter int DEPTH_L = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               execute_branch_valid,
  output logic               execute_branch_ready,
  input  logic [31:0]        execute_branch_PC,
  input  logic [31:0]        execute_branch_target,
  input  logic               execute_branch_dir,
  input  logic               execute_branch_is_cond,
  input  logic               execute_branch_p_dir,
  input  logic [31:0]        execute_branch_p_target,
  input  logic [19:0]        execute_branch_meta,
  input  logic               soin_bpredictor_stall,
  output logic               execute_bpredictor_update,
  output logic [31:0]        execute_bpredictor_PC,
  output logic [31:0]        execute_bpredictor_target,
  output logic               execute_bpredictor_dir,
  output logic               execute_bpredictor_miss,
  output logic [23:0]        execute_bpredictor_meta,
  output logic               execute_bpredictor_recover_ras,
  output logic [DEPTH_L:0]   update_fifo_count
);

  localparam int DEPTH = 1 << DEPTH_L;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        dir;
    logic        is_cond;
    logic        miss;
    logic [19:0] meta;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [DEPTH_L-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_L-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_L:0]   count_q, count_d;

  logic   full, empty;
  logic   in_miss, push, cut_through, fifo_wr, fifo_rd, pop;
  entry_t in_entry, pop_entry;

  logic [1:0] pop_lane, pop_slot;
  logic [7:0] pop_idx;
  logic [7:0] base_byte, new_byte;
  logic [1:0] base_ctr, new_ctr;
  logic [3:0] new_be;

  // Registered outputs
  logic        update_q, dir_q, miss_q, recover_q;
  logic [31:0] pc_q, target_q;
  logic [23:0] meta_q;

`ifdef SOIN_BP_UPDATE_BYPASS_EN
  logic       byp_valid_q;
  logic [7:0] byp_idx_q;
  logic [1:0] byp_lane_q;
  logic [7:0] byp_byte_q;
`endif

  assign full  = (count_q == (DEPTH_L+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Queue control. With an empty FIFO and no stall the incoming entry goes
  // straight to the output registers, giving one-cycle latency without ever
  // occupying a slot (push and pop in the same cycle).
  always_comb begin
    in_miss = (execute_branch_dir != execute_branch_p_dir) |
              (execute_branch_dir & (execute_branch_target != execute_branch_p_target));
    in_entry.pc      = execute_branch_PC;
    in_entry.target  = execute_branch_target;
    in_entry.dir     = execute_branch_dir;
    in_entry.is_cond = execute_branch_is_cond;
    in_entry.miss    = in_miss;
    in_entry.meta    = execute_branch_meta;

    // Correctly predicted unconditional branches have nothing to update.
    push        = execute_branch_valid & ~full & (execute_branch_is_cond | in_miss);
    cut_through = empty & push & ~soin_bpredictor_stall;
    fifo_wr     = push & ~cut_through;
    fifo_rd     = ~empty & ~soin_bpredictor_stall;
    pop         = fifo_rd | cut_through;
    pop_entry   = empty ? in_entry : mem_q[rd_ptr_q];

    wr_ptr_d = fifo_wr ? wr_ptr_q + DEPTH_L'(1) : wr_ptr_q;
    rd_ptr_d = fifo_rd ? rd_ptr_q + DEPTH_L'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   count_d = count_q + (DEPTH_L+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_L+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Counter read-modify-write for the entry being drained. The meta byte
  // holds four 2-bit counters; slot PC[3:2] selects one, PC[5:4] picks the
  // byte lane written in the predictor.
  always_comb begin
    pop_lane  = pop_entry.pc[5:4];
    pop_slot  = pop_entry.pc[3:2];
    pop_idx   = pop_entry.meta[7:0];
    base_byte = pop_entry.meta[15:8];
`ifdef SOIN_BP_UPDATE_BYPASS_EN
    if (byp_valid_q && (byp_idx_q == pop_idx) && (byp_lane_q == pop_lane)) begin
      base_byte = byp_byte_q;
    end
`endif
    base_ctr = base_byte[{pop_slot, 1'b0} +: 2];
    if (pop_entry.dir) begin
      new_ctr = (base_ctr == 2'd3) ? 2'd3 : base_ctr + 2'd1;
    end else begin
      new_ctr = (base_ctr == 2'd0) ? 2'd0 : base_ctr - 2'd1;
    end
    new_byte = base_byte;
    new_byte[{pop_slot, 1'b0} +: 2] = new_ctr;
    new_be = 4'b0001 << pop_lane;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      update_q  <= 1'b0;
      dir_q     <= 1'b0;
      miss_q    <= 1'b0;
      recover_q <= 1'b0;
      pc_q      <= '0;
      target_q  <= '0;
      meta_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop) begin
        update_q  <= pop_entry.is_cond;
        miss_q    <= pop_entry.miss;
        recover_q <= pop_entry.miss;
        dir_q     <= pop_entry.dir;
        pc_q      <= pop_entry.pc;
        target_q  <= pop_entry.target;
        meta_q    <= {pop_entry.meta[19:16], new_be, new_byte, pop_idx};
      end else begin
        // Strobes drop after one cycle; data fields keep the last entry.
        update_q  <= 1'b0;
        miss_q    <= 1'b0;
        recover_q <= 1'b0;
      end
    end
  end

  // Storage is not reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

`ifdef SOIN_BP_UPDATE_BYPASS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      byp_valid_q <= 1'b0;
      byp_idx_q   <= '0;
      byp_lane_q  <= '0;
      byp_byte_q  <= '0;
    end else if (pop && pop_entry.is_cond) begin
      byp_valid_q <= 1'b1;
      byp_idx_q   <= pop_idx;
      byp_lane_q  <= pop_lane;
      byp_byte_q  <= new_byte;
    end
  end
`endif

  assign execute_branch_ready           = ~full;
  assign execute_bpredictor_update      = update_q;
  assign execute_bpredictor_PC          = pc_q;
  assign execute_bpredictor_target      = target_q;
  assign execute_bpredictor_dir         = dir_q;
  assign execute_bpredictor_miss        = miss_q;
  assign execute_bpredictor_meta        = meta_q;
  assign execute_bpredictor_recover_ras = recover_q;
  assign update_fifo_count              = count_q;

endmodule

// File: tb/tb_soin_bpredictor_update_fifo.sv
`timescale 1ns/1ps
module tb_soin_bpredictor_update_fifo;
  localparam int DEPTH_L = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid = 1'b0, stall = 1'b0, dir = 1'b0, is_cond = 1'b0, p_dir = 1'b0;
  logic [31:0] pc = '0, tgt = '0, p_tgt = '0;
  logic [19:0] meta_in = '0;
  logic ready, upd, miss, rec, odir;
  logic [31:0] opc, otgt;
  logic [23:0] ometa;
  logic [DEPTH_L:0] cnt;

  int checks = 0;
  int failures = 0;
  int pop_cnt = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        dir;
    logic        upd;
    logic        miss;
    logic [23:0] meta;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference-model state: counter byte written by the last conditional pop.
  bit         h_valid = 0;
  logic [7:0] h_idx;
  int         h_lane;
  logic [7:0] h_byte;

  soin_bpredictor_update_fifo #(.DEPTH_L(DEPTH_L)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .execute_branch_valid           (valid),
    .execute_branch_ready           (ready),
    .execute_branch_PC              (pc),
    .execute_branch_target          (tgt),
    .execute_branch_dir             (dir),
    .execute_branch_is_cond         (is_cond),
    .execute_branch_p_dir           (p_dir),
    .execute_branch_p_target        (p_tgt),
    .execute_branch_meta            (meta_in),
    .soin_bpredictor_stall          (stall),
    .execute_bpredictor_update      (upd),
    .execute_bpredictor_PC          (opc),
    .execute_bpredictor_target      (otgt),
    .execute_bpredictor_dir         (odir),
    .execute_bpredictor_miss        (miss),
    .execute_bpredictor_meta        (ometa),
    .execute_bpredictor_recover_ras (rec),
    .update_fifo_count              (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Expected output for an accepted entry, from the rules in plain arithmetic.
  task automatic model_push();
    exp_t e;
    bit   m;
    int   lane, slot, base, c, nb;
    m = (dir != p_dir) || (dir && (tgt != p_tgt));
    if (!(is_cond || m)) return;
    lane = int'(pc[5:4]);
    slot = int'(pc[3:2]);
    base = int'(meta_in[15:8]);
`ifdef SOIN_BP_UPDATE_BYPASS_EN
    if (is_cond && h_valid && (h_idx == meta_in[7:0]) && (h_lane == lane)) base = int'(h_byte);
`endif
    c  = (base >> (2 * slot)) & 3;
    c  = dir ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
    nb = (base & ~(3 << (2 * slot))) | (c << (2 * slot));
    e.pc   = pc;
    e.tgt  = tgt;
    e.dir  = dir;
    e.upd  = is_cond;
    e.miss = m;
    e.meta = {meta_in[19:16], 4'(1 << lane), 8'(nb), meta_in[7:0]};
    if (is_cond) begin
      h_valid = 1;
      h_idx   = meta_in[7:0];
      h_lane  = lane;
      h_byte  = 8'(nb);
    end
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; presents one entry for one cycle.
  task automatic send(input logic [31:0] a_pc, input logic [31:0] a_tgt, input logic [31:0] a_ptgt,
                      input logic a_dir, input logic a_pdir, input logic a_cond,
                      input logic [19:0] a_meta, output bit acc);
    pc = a_pc; tgt = a_tgt; p_tgt = a_ptgt;
    dir = a_dir; p_dir = a_pdir; is_cond = a_cond; meta_in = a_meta;
    valid = 1'b1;
    acc = ready;
    if (acc) model_push();
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Let the monitor observe everything up to the last edge, then realign.
  task automatic sync_mon();
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Monitor: every pop shows update or recover_ras, since only cond or miss
  // entries are queued.
  initial begin
    forever begin
      @(negedge clk);
      if (upd || rec) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual=pc_0x%0h required=no_pop", opc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pop_pc", 64'(opc), 64'(mon_e.pc));
          chk("pop_target", 64'(otgt), 64'(mon_e.tgt));
          chk("pop_dir", 64'(odir), 64'(mon_e.dir));
          chk("pop_update", 64'(upd), 64'(mon_e.upd));
          chk("pop_miss", 64'(miss), 64'(mon_e.miss));
          chk("pop_recover", 64'(rec), 64'(mon_e.miss));
          if (mon_e.upd) chk("pop_meta", 64'(ometa), 64'(mon_e.meta));
          else chk("pop_meta_ras_idx", 64'(ometa & 24'hF000FF), 64'(mon_e.meta & 24'hF000FF));
        end
      end else begin
        chk("idle_miss", 64'(miss), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int base;
    bit pend;
    logic [31:0] r_pc, r_tgt, r_ptgt, r_tmp;
    logic [19:0] r_meta;
    logic r_dir, r_pdir, r_cond;
    int t;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_update", 64'(upd), 0);
    chk("rst_miss", 64'(miss), 0);
    chk("rst_recover", 64'(rec), 0);
    chk("rst_ready", 64'(ready), 1);
    chk("rst_count", 64'(cnt), 0);
    chk("rst_pc", 64'(opc), 0);
    chk("rst_meta", 64'(ometa), 0);

    // 1: basic correct prediction, one-cycle latency
    send(32'h100, 32'h200, 32'h200, 1, 1, 1, {4'h3, 8'h01, 8'h2A}, acc);
    chk("t1_accept", 64'(acc), 1);
    chk("t1_update_n1", 64'(upd), 1);
    chk("t1_miss", 64'(miss), 0);
    chk("t1_meta", 64'(ometa), 64'h31022A);

    // 2: saturation at both ends
    send(32'h10C, 32'h200, 32'h200, 1, 1, 1, {4'h0, 8'hC0, 8'h10}, acc);
    chk("t2_sat_hi", 64'(ometa), 64'h01C010);
    send(32'h100, 32'h200, 32'h300, 0, 0, 1, {4'h0, 8'h00, 8'h11}, acc);
    chk("t2_sat_lo", 64'(ometa), 64'h010011);
    idle(2);

    // 3: fill under stall, full hold-off, in-order consecutive drain
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h200 + 32'(i * 16), 32'h900, 32'h900, 1'(i & 1), 1'(i & 1), 1,
           {4'h1, 8'h5A, 8'(8'h40 + i)}, acc);
      chk("t3_accept", 64'(acc), 1);
    end
    chk("t3_count_full", 64'(cnt), 4);
    chk("t3_ready_full", 64'(ready), 0);
    send(32'h240, 32'h900, 32'h900, 1, 1, 1, {4'h1, 8'h5A, 8'h44}, acc);
    chk("t3_fifth_held", 64'(acc), 0);
    chk("t3_count_held", 64'(cnt), 4);
    base = pop_cnt;
    stall = 1'b0;
    send(32'h240, 32'h900, 32'h900, 1, 1, 1, {4'h1, 8'h5A, 8'h44}, acc);
    chk("t3_still_full_at_release", 64'(acc), 0);
    send(32'h240, 32'h900, 32'h900, 1, 1, 1, {4'h1, 8'h5A, 8'h44}, acc);
    chk("t3_fifth_accepted", 64'(acc), 1);
    idle(3);
    @(negedge clk); #1;
    chk("t3_consecutive_pops", 64'(pop_cnt - base), 5);
    @(posedge clk); #1;

    // 4: mispredictions
    send(32'h300, 32'h400, 32'h400, 1, 0, 1, {4'h7, 8'h55, 8'h60}, acc);
    chk("t4_cond_miss", 64'(miss), 1);
    chk("t4_cond_recover", 64'(rec), 1);
    chk("t4_cond_update", 64'(upd), 1);
    chk("t4_ras", 64'(ometa[23:20]), 64'h7);
    send(32'h310, 32'h500, 32'h504, 1, 1, 0, {4'h9, 8'h00, 8'h61}, acc);
    chk("t4_noncond_update", 64'(upd), 0);
    chk("t4_noncond_recover", 64'(rec), 1);
    chk("t4_noncond_ras", 64'(ometa[23:20]), 64'h9);
    sync_mon();
    base = pop_cnt;
    send(32'h320, 32'h500, 32'h504, 0, 0, 0, {4'h2, 8'h00, 8'h62}, acc);
    sync_mon();
    chk("t4_drop_no_pop", 64'(pop_cnt - base), 0);
    chk("t4_drop_count", 64'(cnt), 0);

    // 5: back-to-back same counter
    send(32'h120, 32'h800, 32'h800, 1, 1, 1, {4'h0, 8'h01, 8'h77}, acc);
    chk("t5_first_byte", 64'(ometa[15:8]), 64'h02);
    send(32'h120, 32'h800, 32'h800, 1, 1, 1, {4'h0, 8'h01, 8'h77}, acc);
`ifdef SOIN_BP_UPDATE_BYPASS_EN
    chk("t5_second_byte", 64'(ometa[15:8]), 64'h03);
`else
    chk("t5_second_byte", 64'(ometa[15:8]), 64'h02);
`endif

    // 6: reset discards queued entries and the held counter byte
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(32'h120, 32'h800, 32'h800, 1, 1, 1, {4'h0, 8'h01, 8'h77}, acc);
    end
    chk("t6_count_before", 64'(cnt), 3);
    reset = 1'b1;
    exp_q.delete();
    h_valid = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    stall = 1'b0;
    chk("t6_count_after", 64'(cnt), 0);
    chk("t6_update_after", 64'(upd), 0);
    chk("t6_ready_after", 64'(ready), 1);
    base = pop_cnt;
    idle(4);
    sync_mon();
    chk("t6_no_stale_pops", 64'(pop_cnt - base), 0);
    send(32'h120, 32'h800, 32'h800, 1, 1, 1, {4'h0, 8'h01, 8'h77}, acc);
    chk("t6_bypass_cleared", 64'(ometa[15:8]), 64'h02);

    // Randomized traffic; a refused entry is held until accepted.
    pend = 0;
    for (int i = 0; i < 500; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      if (!pend && ($urandom_range(0, 99) < 75)) begin
        r_pc = $urandom();
        r_pc[1:0] = 2'b00;
        r_tgt = $urandom();
        r_tmp = $urandom();
        r_ptgt = ($urandom_range(0, 1) == 1) ? r_tgt : r_tmp;
        r_tmp = $urandom();
        r_meta = r_tmp[19:0];
        r_meta[7:0] = 8'($urandom_range(0, 3));
        r_dir = 1'($urandom_range(0, 1));
        r_pdir = 1'($urandom_range(0, 1));
        r_cond = ($urandom_range(0, 3) != 0);
        pend = 1;
      end
      if (pend) begin
        send(r_pc, r_tgt, r_ptgt, r_dir, r_pdir, r_cond, r_meta, acc);
        if (acc) pend = 0;
      end else begin
        idle(1);
      end
    end
    stall = 1'b0;
    t = 0;
    while (exp_q.size() > 0 && t < 50) begin
      idle(1);
      t++;
    end
    sync_mon();
    chk("drain_empty", 64'(exp_q.size()), 0);
    chk("drain_count", 64'(cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
